// File: rtl/rib_xbar.sv
// rib_xbar: shared-path interconnect from NUM_MASTERS bus masters to NUM_SLAVES memory-mapped slaves.
// Optional feature macro RIB_RR_EN selects round-robin arbitration; undefined gives fixed priority.

module rib_xbar_slot #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              wr_hit,
  input  logic              rd_hit,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              s_wr_en,
  output logic [ADDR_W-1:0] s_wr_addr,
  output logic [DATA_W-1:0] s_wr_data,
  output logic [ADDR_W-1:0] s_rd_addr
);
  assign s_wr_en   = wr_hit & wr_en;
  assign s_wr_addr = wr_hit ? wr_addr : '0;
  assign s_wr_data = wr_hit ? wr_data : '0;
  assign s_rd_addr = rd_hit ? rd_addr : '0;
endmodule

module rib_xbar_lane #(
  parameter int DATA_W = 32
) (
  input  logic              req,
  input  logic              grant,
  input  logic [DATA_W-1:0] rd_data,
  output logic              hold,
  output logic [DATA_W-1:0] m_rd_data
);
  assign hold      = req & ~grant;
  assign m_rd_data = grant ? rd_data : '0;
endmodule

module rib_xbar #(
  parameter int NUM_MASTERS = 3,
  parameter int NUM_SLAVES  = 5,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = 28,
  parameter int MAX_HOLD    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_wr_req_i,
  input  logic [NUM_MASTERS-1:0]        m_wr_en_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_wr_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data_i,
  input  logic [NUM_MASTERS-1:0]        m_rd_req_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_rd_addr_i,
  output logic [NUM_MASTERS*DATA_W-1:0] m_rd_data_o,
  output logic [NUM_MASTERS-1:0]        m_hold_o,
  output logic [NUM_SLAVES-1:0]         s_wr_en_o,
  output logic [NUM_SLAVES*ADDR_W-1:0]  s_wr_addr_o,
  output logic [NUM_SLAVES*DATA_W-1:0]  s_wr_data_o,
  output logic [NUM_SLAVES*ADDR_W-1:0]  s_rd_addr_o,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rd_data_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          err_o
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = ADDR_W - SEL_LSB;
  localparam int HW = $clog2(MAX_HOLD + 2);
  localparam logic [ADDR_W-1:0] LOW_MASK = {ADDR_W{1'b1}} >> SW;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state;
  logic [MW-1:0]          owner;
  logic [HW-1:0]          hold_cnt;
  logic [NUM_MASTERS-1:0] grant_q;
  logic                   err_q;
`ifdef RIB_RR_EN
  logic [MW-1:0]          last_owner;
`endif

  logic [NUM_MASTERS-1:0][ADDR_W-1:0] wr_addr_m, rd_addr_m;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] wr_data_m, rd_slot;
  logic [NUM_SLAVES-1:0][DATA_W-1:0]  s_rd_data, s_wd;
  logic [NUM_SLAVES-1:0][ADDR_W-1:0]  s_wa, s_ra;
  logic [NUM_SLAVES-1:0]              wr_hit, rd_hit;

  assign wr_addr_m   = m_wr_addr_i;
  assign rd_addr_m   = m_rd_addr_i;
  assign wr_data_m   = m_wr_data_i;
  assign s_rd_data   = s_rd_data_i;
  assign s_wr_addr_o = s_wa;
  assign s_wr_data_o = s_wd;
  assign s_rd_addr_o = s_ra;
  assign m_rd_data_o = rd_slot;
  assign grant_o     = grant_q;
  assign err_o       = err_q;

  // Owner-side decode; read and write select fields are decoded independently.
  logic [NUM_MASTERS-1:0] req;
  logic                   owned, wr_act, rd_act, wr_map, rd_map, err_nxt;
  logic [ADDR_W-1:0]      own_wa, own_ra;
  logic [SW-1:0]          wr_sel, rd_sel;
  logic [DATA_W-1:0]      rd_mux;

  assign req     = m_wr_req_i | m_rd_req_i;
  assign owned   = (state == OWNED);
  assign wr_act  = owned & m_wr_req_i[owner];
  assign rd_act  = owned & m_rd_req_i[owner];
  assign own_wa  = wr_addr_m[owner];
  assign own_ra  = rd_addr_m[owner];
  assign wr_sel  = own_wa[ADDR_W-1:SEL_LSB];
  assign rd_sel  = own_ra[ADDR_W-1:SEL_LSB];
  assign wr_map  = int'(wr_sel) < NUM_SLAVES;
  assign rd_map  = int'(rd_sel) < NUM_SLAVES;
  assign rd_mux  = (rd_act && rd_map) ? s_rd_data[rd_sel] : '0;
  assign err_nxt = (wr_act & ~wr_map) | (rd_act & ~rd_map);

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slot
    assign wr_hit[s] = wr_act & wr_map & (int'(wr_sel) == s);
    assign rd_hit[s] = rd_act & rd_map & (int'(rd_sel) == s);
    rib_xbar_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .wr_hit   (wr_hit[s]),
      .rd_hit   (rd_hit[s]),
      .wr_en    (m_wr_en_i[owner]),
      .wr_addr  (own_wa & LOW_MASK),
      .wr_data  (wr_data_m[owner]),
      .rd_addr  (own_ra & LOW_MASK),
      .s_wr_en  (s_wr_en_o[s]),
      .s_wr_addr(s_wa[s]),
      .s_wr_data(s_wd[s]),
      .s_rd_addr(s_ra[s])
    );
  end

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_lane
    rib_xbar_lane #(.DATA_W(DATA_W)) u_lane (
      .req      (req[m]),
      .grant    (grant_q[m]),
      .rd_data  (rd_mux),
      .hold     (m_hold_o[m]),
      .m_rd_data(rd_slot[m])
    );
  end

  // Arbitration: preemption masks the current owner out of one rearbitration.
  logic                   others, preempt, rearb, win_vld;
  logic [NUM_MASTERS-1:0] cand;
  logic [MW-1:0]          win, idx;
  int                     base;

  assign others  = |(req & ~grant_q);
  assign preempt = (MAX_HOLD != 0) && owned && req[owner] && others &&
                   (int'(hold_cnt) == MAX_HOLD - 1);
  assign rearb   = owned ? (!req[owner] || preempt) : |req;
  assign cand    = preempt ? (req & ~grant_q) : req;
`ifdef RIB_RR_EN
  assign base    = int'(last_owner) + 1;
`else
  assign base    = 0;
`endif

  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = MW'((base + k) % NUM_MASTERS);
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      hold_cnt   <= '0;
      grant_q    <= '0;
      err_q      <= 1'b0;
`ifdef RIB_RR_EN
      last_owner <= MW'(NUM_MASTERS - 1);
`endif
    end else begin
      err_q <= err_nxt;
      if (rearb) begin
        hold_cnt <= '0;
        if (win_vld) begin
          state      <= OWNED;
          owner      <= win;
          grant_q    <= NUM_MASTERS'(1) << win;
`ifdef RIB_RR_EN
          last_owner <= win;
`endif
        end else begin
          state   <= IDLE;
          grant_q <= '0;
        end
      end else if (owned && others && hold_cnt != {HW{1'b1}}) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/rib_xbar.md
# rib_xbar

Parametrised successor to the system bus interconnect: connects `NUM_MASTERS` bus masters to `NUM_SLAVES` memory-mapped slaves through a single shared path.
- Masters are the core data port, the UART debug loader and future DMA.
- Slaves are ROM, RAM, UART, GPIO, timer and future peripherals.
- Adds a registered grant with round-robin or fixed-priority arbitration, ownership lock, a starvation guard and unmapped-address error reporting.
- Sits between masters and slaves in the SoC top; drives per-master hold flags into the core pipeline stall logic.

## Interface
Parameters:
- NUM_MASTERS, 3, number of masters (1–8)
- NUM_SLAVES, 5, number of slaves (1–16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_LSB, 28, lowest bit of slave-select field; field is addr[ADDR_W-1:SEL_LSB]
- MAX_HOLD, 16, max contiguous owned cycles while others wait; 0 disables preemption

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m_wr_req_i  in  NUM_MASTERS  per-master write request
- m_wr_en_i  in  NUM_MASTERS  per-master write strobe
- m_wr_addr_i  in  NUM_MASTERS*ADDR_W  flattened write addresses, master i at [i*ADDR_W +: ADDR_W]
- m_wr_data_i  in  NUM_MASTERS*DATA_W  flattened write data
- m_rd_req_i  in  NUM_MASTERS  per-master read request
- m_rd_addr_i  in  NUM_MASTERS*ADDR_W  flattened read addresses
- m_rd_data_o  out  NUM_MASTERS*DATA_W  read data; only the owner's slot is nonzero
- m_hold_o  out  NUM_MASTERS  stall: requesting but not owner
- s_wr_en_o  out  NUM_SLAVES  per-slave write strobe
- s_wr_addr_o  out  NUM_SLAVES*ADDR_W  per-slave write address, select field cleared
- s_wr_data_o  out  NUM_SLAVES*DATA_W  per-slave write data
- s_rd_addr_o  out  NUM_SLAVES*ADDR_W  per-slave read address, select field cleared
- s_rd_data_i  in  NUM_SLAVES*DATA_W  combinational slave read data
- grant_o  out  NUM_MASTERS  registered one-hot owner, all zero when idle
- err_o  out  1  registered unmapped-access pulse

## Operation
Request and ownership:
- req[i] = m_wr_req_i[i] | m_rd_req_i[i].
- States:
  - IDLE: no owner.
  - OWNED: owner index valid.
- Rearbitration occurs on any of:
  - IDLE with any req.
  - Owner's req low (release).
  - Preemption.
- The winner is registered into the owner at the next edge. Release hands ownership directly to the next requester with no idle cycle. With no requester, the state goes to IDLE.

Arbitration:
- Round-robin: search starts at (last_owner+1) mod NUM_MASTERS.
- last_owner resets to NUM_MASTERS-1, so master 0 wins first.

Starvation guard:
- hold_cnt increments each OWNED cycle in which any non-owner requests; it clears on owner change.
- When hold_cnt == MAX_HOLD-1 and another master requests, rearbitration excludes the current owner.

Data path:
- Owner's select field S < NUM_SLAVES: routes to slave S.
  - s_wr_en_o[S] = owner m_wr_en_i & m_wr_req_i.
  - Addresses and data go to slot S; all other slots are zero.
  - m_rd_data_o owner slot = s_rd_data_i slot S.
- S ≥ NUM_SLAVES (unmapped):
  - Writes are dropped and read data is 0.
  - err_o is 1 in the following cycle, for each cycle the access persists.
- Write and read paths decode independently; both may target different slaves in the same cycle.

Hold flags:
- m_hold_o = req & ~grant_o, combinational from the registered grant.

## Timing
Reset values:
- grant_o, err_o, m_hold_o (req masked), all s_* outputs and all m_rd_data_o are 0.
- State is IDLE, hold_cnt is 0, last_owner is NUM_MASTERS-1.

Latency:
- Arbitration latency is 1 cycle: a request in cycle t from IDLE is granted at t+1. The master sees m_hold_o high in t and low in t+1.
- Slave strobes and read data are combinational from grant_o and master inputs: zero-cycle data path once owned.

Boundary conditions:
- Simultaneous release by the owner and a new request: the new requester is granted at the next edge.
- Reset asserted mid-transaction: all outputs clear asynchronously; there is no partial write beyond the current cycle.
- Owner switching between read and write while holding req keeps ownership.

## Configuration
- RIB_RR_EN defined: round-robin arbitration as above.
- RIB_RR_EN undefined: fixed priority, with the lowest index always winning. Preemption still excludes the current owner for that one rearbitration.

## Test plan
- Reset then master 1 write 0x2000_0004 ← 0xA5A5_A5A5 → m_hold_o[1]=1 in cycle 0; grant_o=3'b010 and s_wr_en_o[2]=1 with addr 0x0000_0004 in cycle 1.
- Masters 0 and 2 request continuously with RIB_RR_EN → grants alternate 0,2,0,2 on each release. Without RIB_RR_EN, master 0 keeps winning.
- Master 0 holds req for 40 cycles with MAX_HOLD=16 while master 1 waits → grant moves to master 1 after 16 owned cycles.
- Read 0xF000_0000 with NUM_SLAVES=5 → m_rd_data_o slot = 0, no s_* strobe, err_o=1 the following cycle.
- Master 0 reads RAM (0x1000_0010 returning 0x1234_5678) while master 1 requests → only master 0's slot = 0x1234_5678; m_hold_o[1]=1.
- Assert rst mid-write → s_wr_en_o and grant_o drop to 0 immediately; after release, the first request is re-granted with 1-cycle latency.
